uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles mem_valid stays high awaiting mem_ready; legal range 1..65535.
REQ-002 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data_valid  input  1  command byte available, from the UART RX FIFO.
REQ-005 SHALL have port rx_data_ready  output  1  command byte accepted when both valid and ready are high.
REQ-006 SHALL have port rx_data_bits  input  8  command byte.
REQ-007 SHALL have port tx_data_valid  output  1  response byte available, to the UART TX FIFO.
REQ-008 SHALL have port tx_data_ready  input  1  response byte consumed when both valid and ready are high.
REQ-009 SHALL have port tx_data_bits  output  8  response byte.
REQ-010 SHALL have port mem_valid  output  1  bus request (native picorv32-style initiator).
REQ-011 SHALL have port mem_instr  output  1  constant 0.
REQ-012 SHALL have port mem_ready  input  1  responder completion.
REQ-013 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-014 SHALL have port mem_wdata  output  32  write data.
REQ-015 SHALL have port mem_wstrb  output  4  4'b1111 for writes, 4'b0000 for reads.
REQ-016 SHALL have port mem_rdata  input  32  read data, valid in the cycle mem_ready is high.

Function
REQ-017 SHALL implement the states IDLE, ADDR, DATA, BUS, RESP.
REQ-018 SHALL drive rx_data_ready high in IDLE, ADDR and DATA, and low in BUS, RESP and during reset.
REQ-019 IDLE, accepted byte handling:
- 0x57 'W': set write flag, go to ADDR.
- 0x52 'R': clear write flag, go to ADDR.
- Any other byte: queue the single response byte 0x3F, go to RESP.
REQ-020 ADDR SHALL accept 4 address bytes, least significant first, then go to DATA if write, else BUS.
REQ-021 DATA SHALL accept 4 data bytes, least significant first, then go to BUS.
REQ-022 SHALL count bytes with a 2-bit counter, cleared on every state entry; it wraps from 3 to 0 on the 4th accepted byte.
REQ-023 On the cycle after the final operand byte is accepted, SHALL assert mem_valid with stable mem_addr, mem_wdata and mem_wstrb.
REQ-024 SHALL hold all mem_* outputs constant while mem_valid is high.
REQ-025 On the first cycle mem_valid and mem_ready are both high, SHALL deassert mem_valid on the next cycle and capture mem_rdata for reads.
REQ-026 Response queued on completion:
- Write: one byte, 0x4B 'K'.
- Read: 0x52 'R', then the 4 captured bytes, least significant first.
REQ-027 SHALL count cycles with mem_valid high; if the count reaches TIMEOUT_CYCLES without mem_ready, SHALL deassert mem_valid and queue the single byte 0x54 'T'.
REQ-028 If mem_ready arrives in the same cycle the timeout is reached, SHALL treat it as normal completion.
REQ-029 SHALL ignore mem_ready whenever mem_valid is low.
REQ-030 RESP SHALL present each response byte with tx_data_valid high and tx_data_bits stable until tx_data_ready, advancing on each handshake.
REQ-031 After the last response handshake, SHALL drop tx_data_valid on the next cycle and return to IDLE.
REQ-032 Minimum latency SHALL be one cycle from the last operand handshake to mem_valid, and one cycle from mem_ready to tx_data_valid.

Reset
REQ-033 While reset is high, SHALL force state IDLE and clear the byte counter, timeout counter and write flag.
REQ-034 While reset is high, SHALL force mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, tx_data_valid=0, tx_data_bits=0 and rx_data_ready=0.
REQ-035 Reset asserted mid-command or mid-transaction SHALL abandon the operation with no response emitted; the first byte after reset SHALL be decoded as a command byte.

Verification
REQ-036 Write: bytes 57 00 00 00 30 AA 00 00 00 -> one request, mem_addr=0x3000_0000, mem_wdata=0x0000_00AA, mem_wstrb=F; mem_ready 2 cycles later -> TX byte 4B.
REQ-037 Read: bytes 52 04 00 00 30, responder returns 0x0123_4567 -> mem_wstrb=0; TX bytes 52 67 45 23 01.
REQ-038 Timeout: TIMEOUT_CYCLES=8, read with mem_ready held low -> mem_valid high exactly 8 cycles, then TX 54; a later mem_ready pulse is ignored.
REQ-039 Bad command 0x00 -> TX 3F, no mem_valid; the next 'R' command is decoded normally.
REQ-040 Backpressure: tx_data_ready low 5 cycles on each byte -> tx_data_bits stable while tx_data_valid is high, no byte lost or duplicated; rx_data_ready stays 0 until the final byte is sent.
REQ-041 Reset after 3 address bytes -> no bus request, no TX; a following full write completes with correct mem_addr.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART command bridge: decodes 'W'/'R' byte frames from an RX FIFO into single-word
// picorv32-style native bus transfers and streams a short response back to a TX FIFO.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    input  logic [7:0]  rx_data_bits,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic [7:0]  tx_data_bits,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);

    // Handshakes: a byte/word moves on a rising clock edge where valid and ready are
    // both high; a producer holds valid and its payload stable until that edge.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [7:0]  CMD_WRITE    = 8'h57;
    localparam logic [7:0]  CMD_READ     = 8'h52;
    localparam logic [7:0]  RSP_OK       = 8'h4B;
    localparam logic [7:0]  RSP_READ     = 8'h52;
    localparam logic [7:0]  RSP_TIMEOUT  = 8'h54;
    localparam logic [7:0]  RSP_BAD      = 8'h3F;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic        write_flag;
    logic [15:0] tcnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [39:0] resp_q;
    logic [2:0]  resp_left;

    logic rx_fire;
    logic tx_fire;
    logic bus_done;
    logic bus_timeout;
    logic is_cmd;

    assign rx_fire     = rx_data_valid && rx_data_ready;
    assign tx_fire     = tx_data_valid && tx_data_ready;
    assign bus_done    = mem_valid && mem_ready;
    // A completion in the same cycle as the last allowed wait wins over the timeout.
    assign bus_timeout = mem_valid && !mem_ready && (tcnt == TIMEOUT_LAST);
    assign is_cmd      = (rx_data_bits == CMD_WRITE) || (rx_data_bits == CMD_READ);

    assign tx_data_bits = resp_q[7:0];
    assign mem_wdata    = wdata_q;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_instr    = 1'b0;
    assign dbg_state    = state;

    always_comb begin
        state_next    = state;
        rx_data_ready = 1'b0;
        case (state)
            S_IDLE: begin
                rx_data_ready = !reset;
                if (rx_fire) state_next = is_cmd ? S_ADDR : S_RESP;
            end
            S_ADDR: begin
                rx_data_ready = !reset;
                if (rx_fire && byte_cnt == 2'd3) state_next = write_flag ? S_DATA : S_BUS;
            end
            S_DATA: begin
                rx_data_ready = !reset;
                if (rx_fire && byte_cnt == 2'd3) state_next = S_BUS;
            end
            S_BUS: begin
                if (bus_done || bus_timeout) state_next = S_RESP;
            end
            S_RESP: begin
                if (tx_fire && resp_left == 3'd1) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            byte_cnt      <= 2'd0;
            write_flag    <= 1'b0;
            tcnt          <= 16'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            mem_valid     <= 1'b0;
            mem_wstrb     <= 4'd0;
            tx_data_valid <= 1'b0;
            resp_q        <= 40'd0;
            resp_left     <= 3'd0;
        end else begin
            state <= state_next;

            if (state_next != state) byte_cnt <= 2'd0;
            else if (rx_fire)        byte_cnt <= byte_cnt + 2'd1;

            if (state == S_IDLE && rx_fire) begin
                if (rx_data_bits == CMD_WRITE)     write_flag <= 1'b1;
                else if (rx_data_bits == CMD_READ) write_flag <= 1'b0;
            end

            // Operands arrive least significant byte first, so shift in from the top.
            if (state == S_ADDR && rx_fire) addr_q  <= {rx_data_bits, addr_q[31:8]};
            if (state == S_DATA && rx_fire) wdata_q <= {rx_data_bits, wdata_q[31:8]};

            if (state != S_BUS && state_next == S_BUS) begin
                mem_valid <= 1'b1;
                mem_wstrb <= write_flag ? 4'hF : 4'h0;
                tcnt      <= 16'd0;
            end else if (mem_valid) begin
                if (bus_done || bus_timeout) mem_valid <= 1'b0;
                else                         tcnt      <= tcnt + 16'd1;
            end

            if (state == S_IDLE && rx_fire && !is_cmd) begin
                resp_q        <= {32'd0, RSP_BAD};
                resp_left     <= 3'd1;
                tx_data_valid <= 1'b1;
            end else if (bus_done) begin
                resp_q        <= write_flag ? {32'd0, RSP_OK} : {mem_rdata, RSP_READ};
                resp_left     <= write_flag ? 3'd1 : 3'd5;
                tx_data_valid <= 1'b1;
            end else if (bus_timeout) begin
                resp_q        <= {32'd0, RSP_TIMEOUT};
                resp_left     <= 3'd1;
                tx_data_valid <= 1'b1;
            end else if (state == S_RESP && tx_fire) begin
                if (resp_left == 3'd1) begin
                    tx_data_valid <= 1'b0;
                    resp_left     <= 3'd0;
                end else begin
                    resp_q    <= {8'd0, resp_q[39:8]};
                    resp_left <= resp_left - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: byte-frame driver, scripted bus responder,
// stalling TX sink, and queue-based scoreboards for bus requests and response bytes.
module tb_uart_bus_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  rx_data_bits;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [7:0]  tx_data_bits;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    uart_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_data_bits  (rx_data_bits),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_data_bits  (tx_data_bits),
        .mem_valid     (mem_valid),
        .mem_instr     (mem_instr),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .dbg_state     (dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    logic [7:0]  exp_tx_q[$];
    logic [67:0] exp_mem_q[$];   // {addr, wdata, wstrb}

    int          resp_delay = 0;   // -1: responder never answers
    logic [31:0] resp_rdata = 32'd0;
    int          pulse_req  = 0;
    int          tx_stall   = 0;
    int          last_len   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_valid = 1'b1;
        rx_data_bits  = b;
        @(negedge clock);
        while (!rx_data_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (rx_data_ready) passes++;
        else $display("FAIL rx_accept: byte %h not accepted after %0d cycles, required under 200", b, n);
        @(posedge clock);
        #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic expect_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_mem_q.push_back({a, d, s});
    endtask

    task automatic expect_tx(input logic [7:0] bytes[$]);
        foreach (bytes[i]) exp_tx_q.push_back(bytes[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_tx_q.size() != 0 || tx_data_valid) && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n < 400) passes++;
        else $display("FAIL idle_wait: still busy after %0d cycles, required under 400", n);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // ---------------- bus responder ----------------
    initial begin
        int wait_cnt  = 0;
        int pulse_done = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clock);
            #1;
            mem_ready = 1'b0;
            if (pulse_req != pulse_done) begin
                mem_ready  = 1'b1;
                mem_rdata  = 32'hFFFF_FFFF;
                pulse_done = pulse_req;
            end else if (mem_valid && resp_delay >= 0) begin
                if (wait_cnt == resp_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_rdata;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- TX sink with per-byte stall ----------------
    initial begin
        int stall_cnt = 0;
        tx_data_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (tx_data_valid && stall_cnt >= tx_stall) begin
                tx_data_ready = 1'b1;
                stall_cnt     = 0;
            end else if (tx_data_valid) begin
                tx_data_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_data_ready = 1'b0;
                stall_cnt     = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_txv = 1'b0;
        logic        prev_txr = 1'b0;
        logic [7:0]  prev_txb = 8'd0;
        logic        prev_mv  = 1'b0;
        logic        prev_mr  = 1'b0;
        logic [67:0] prev_req = 68'd0;
        logic [67:0] cur_req;
        logic [67:0] exp_req;
        int          mv_len = 0;
        forever begin
            @(negedge clock);
            cur_req = {mem_addr, mem_wdata, mem_wstrb};
            if (reset) begin
                prev_txv = 1'b0;
                prev_txr = 1'b0;
                prev_mv  = 1'b0;
                prev_mr  = 1'b0;
                mv_len   = 0;
            end else begin
                if (prev_txv && !prev_txr) begin
                    check("tx_hold_valid", 32'(tx_data_valid), 32'd1);
                    check("tx_hold_bits", 32'(tx_data_bits), 32'(prev_txb));
                end
                if (prev_mv && prev_mr) check("tx_latency", 32'(tx_data_valid), 32'd1);
                if (tx_data_valid && tx_data_ready) begin
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        $display("FAIL tx_unexpected: got byte %h, required no byte", tx_data_bits);
                    end else begin
                        check("tx_byte", 32'(tx_data_bits), 32'(exp_tx_q.pop_front()));
                    end
                end
                if (tx_data_valid || mem_valid) check("rx_ready_low", 32'(rx_data_ready), 32'd0);

                if (mem_valid && !prev_mv) begin
                    if (exp_mem_q.size() == 0) begin
                        checks++;
                        $display("FAIL mem_unexpected: got request addr %h, required none", mem_addr);
                    end else begin
                        exp_req = exp_mem_q.pop_front();
                        check("mem_addr", mem_addr, exp_req[67:36]);
                        check("mem_wstrb", 32'(mem_wstrb), 32'(exp_req[3:0]));
                        if (exp_req[3:0] == 4'hF) check("mem_wdata", mem_wdata, exp_req[35:4]);
                        check("mem_instr", 32'(mem_instr), 32'd0);
                    end
                end else if (mem_valid && prev_mv) begin
                    check("mem_hold_addr", mem_addr, prev_req[67:36]);
                    check("mem_hold_wdata", mem_wdata, prev_req[35:4]);
                    check("mem_hold_wstrb", 32'(mem_wstrb), 32'(prev_req[3:0]));
                end

                if (mem_valid) mv_len++;
                else if (prev_mv) begin
                    last_len = mv_len;
                    mv_len   = 0;
                end
                prev_txv = tx_data_valid;
                prev_txr = tx_data_ready;
                prev_txb = tx_data_bits;
                prev_mv  = mem_valid;
                prev_mr  = mem_ready;
                prev_req = cur_req;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_data_valid), 32'd0);
        check({tag, "_tx_bits"}, 32'(tx_data_bits), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_data_ready), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset         = 1'b1;
        rx_data_valid = 1'b0;
        rx_data_bits  = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Write with responder answering 2 cycles after the request.
        resp_delay = 2;
        expect_req(32'h3000_0000, 32'h0000_00AA, 4'hF);
        expect_tx('{8'h4B});
        send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h30, 8'hAA, 8'h00, 8'h00, 8'h00});
        wait_idle();
        check("write_valid_len", 32'(last_len), 32'd3);

        // Read.
        resp_rdata = 32'h0123_4567;
        expect_req(32'h3000_0004, 32'd0, 4'h0);
        expect_tx('{8'h52, 8'h67, 8'h45, 8'h23, 8'h01});
        send_frame('{8'h52, 8'h04, 8'h00, 8'h00, 8'h30});
        wait_idle();

        // Timeout with mem_ready held low; a later stray mem_ready pulse must be ignored.
        resp_delay = -1;
        expect_req(32'h4000_0100, 32'd0, 4'h0);
        expect_tx('{8'h54});
        send_frame('{8'h52, 8'h00, 8'h01, 8'h00, 8'h40});
        wait_idle();
        check("timeout_valid_len", 32'(last_len), 32'd8);
        pulse_req++;
        repeat (4) @(posedge clock);
        #1;
        check("stray_ready_mem_valid", 32'(mem_valid), 32'd0);
        check("stray_ready_tx_valid", 32'(tx_data_valid), 32'd0);

        // mem_ready on the final allowed cycle counts as completion; low address bits dropped.
        resp_delay = 7;
        resp_rdata = 32'hCAFE_F00D;
        expect_req(32'h5000_0008, 32'd0, 4'h0);
        expect_tx('{8'h52, 8'h0D, 8'hF0, 8'hFE, 8'hCA});
        send_frame('{8'h52, 8'h0B, 8'h00, 8'h00, 8'h50});
        wait_idle();
        check("edge_valid_len", 32'(last_len), 32'd8);

        // Bad command, then a normal read with zero-wait responder.
        expect_tx('{8'h3F});
        send_byte(8'h00);
        wait_idle();
        resp_delay = 0;
        resp_rdata = 32'hDEAD_BEEF;
        expect_req(32'h3000_0008, 32'd0, 4'h0);
        expect_tx('{8'h52, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        send_frame('{8'h52, 8'h08, 8'h00, 8'h00, 8'h30});
        wait_idle();
        check("zero_wait_valid_len", 32'(last_len), 32'd1);

        // TX backpressure: 5 stall cycles on every response byte.
        tx_stall   = 5;
        resp_delay = 1;
        resp_rdata = 32'h89AB_CDEF;
        expect_req(32'h2000_0010, 32'd0, 4'h0);
        expect_tx('{8'h52, 8'hEF, 8'hCD, 8'hAB, 8'h89});
        send_frame('{8'h52, 8'h10, 8'h00, 8'h00, 8'h20});
        wait_idle();
        expect_req(32'h2000_0014, 32'hA5A5_5A5A, 4'hF);
        expect_tx('{8'h4B});
        send_frame('{8'h57, 8'h14, 8'h00, 8'h00, 8'h20, 8'h5A, 8'h5A, 8'hA5, 8'hA5});
        wait_idle();
        tx_stall = 0;

        // Reset after 3 address bytes abandons the command silently.
        send_frame('{8'h57, 8'h11, 8'h22, 8'h33});
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("midcmd");
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("post_reset_mem_valid", 32'(mem_valid), 32'd0);
        check("post_reset_tx_valid", 32'(tx_data_valid), 32'd0);
        resp_delay = 1;
        expect_req(32'h3000_0020, 32'h1234_5678, 4'hF);
        expect_tx('{8'h4B});
        send_frame('{8'h57, 8'h20, 8'h00, 8'h00, 8'h30, 8'h78, 8'h56, 8'h34, 8'h12});
        wait_idle();
        check("post_reset_valid_len", 32'(last_len), 32'd2);

        check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded 2000000 time units");
        $fatal(1);
    end

endmodule
